// File: rtl/sample_delay.sv
`default_nettype none
// ============================================================================
// Module   : sample_delay
// Purpose  : Delays a stream of {metadata, data} samples by DEPTH accepted
//            samples. The delay counts samples, not clock cycles. A circular
//            buffer holds the pairs. The fill count hides the output until
//            DEPTH samples have been stored.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   WDTH   - data width in bits
//   MWDTH  - metadata width in bits
//   DEPTH  - delay in samples (1..64)
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   in_data   in   input sample
//   in_nd     in   in_data/in_m valid this cycle
//   in_m      in   metadata travelling with the sample
//   flush     in   discard all held samples
//   out_data  out  delayed sample (registered, held while out_nd=0)
//   out_nd    out  one-cycle valid for out_data/out_m
//   out_m     out  delayed metadata (registered, held while out_nd=0)
//   primed    out  buffer holds DEPTH samples
//   error     out  sticky flag: flush and in_nd seen in the same cycle
//   out_count out  16-bit wrapping count of out_nd pulses
//                  (present only when SAMPLE_DELAY_COUNT_EN is defined)
// Optional feature macro: SAMPLE_DELAY_COUNT_EN
// ============================================================================
module sample_delay #(
  parameter int WDTH  = 32,
  parameter int MWDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WDTH-1:0]  in_data,
  input  logic             in_nd,
  input  logic [MWDTH-1:0] in_m,
  input  logic             flush,
  output logic [WDTH-1:0]  out_data,
  output logic             out_nd,
  output logic [MWDTH-1:0] out_m,
  output logic             primed,
  output logic             error
`ifdef SAMPLE_DELAY_COUNT_EN
  ,
  output logic [15:0]      out_count
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW = $clog2(DEPTH + 1);
  localparam int EW = MWDTH + WDTH;

  localparam logic [PW-1:0] C_LAST_PTR = PW'(DEPTH - 1);
  localparam logic [FW-1:0] C_FULL     = FW'(DEPTH);

  // Storage is deliberately not reset. Entries are only observed once fill
  // says they were written since the last reset or flush.
  logic [EW-1:0]    mem_q [DEPTH];

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [WDTH-1:0]  out_data_q, out_data_d;
  logic [MWDTH-1:0] out_m_q, out_m_d;
  logic             out_nd_q, out_nd_d;
  logic             primed_q, primed_d;
  logic             error_q, error_d;

  logic             accept;
  logic [EW-1:0]    rd_entry;

  assign accept   = in_nd & ~flush;
  assign rd_entry = mem_q[wptr_q];

  always_comb begin
    wptr_d     = wptr_q;
    fill_d     = fill_q;
    out_data_d = out_data_q;
    out_m_d    = out_m_q;
    out_nd_d   = 1'b0;
    error_d    = error_q | (flush & in_nd);

    if (flush) begin
      wptr_d = '0;
      fill_d = '0;
    end else if (in_nd) begin
      // The slot about to be overwritten holds the sample accepted exactly
      // DEPTH samples ago. It is valid only once the buffer is full.
      if (fill_q == C_FULL) begin
        out_data_d = rd_entry[WDTH-1:0];
        out_m_d    = rd_entry[EW-1:WDTH];
        out_nd_d   = 1'b1;
      end else begin
        fill_d = fill_q + FW'(1);
      end
      wptr_d = (wptr_q == C_LAST_PTR) ? '0 : wptr_q + PW'(1);
    end

    primed_d = (fill_d == C_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      fill_q     <= '0;
      out_data_q <= '0;
      out_m_q    <= '0;
      out_nd_q   <= 1'b0;
      primed_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      fill_q     <= fill_d;
      out_data_q <= out_data_d;
      out_m_q    <= out_m_d;
      out_nd_q   <= out_nd_d;
      primed_q   <= primed_d;
      error_q    <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wptr_q] <= {in_m, in_data};
    end
  end

  assign out_data = out_data_q;
  assign out_m    = out_m_q;
  assign out_nd   = out_nd_q;
  assign primed   = primed_q;
  assign error    = error_q;

`ifdef SAMPLE_DELAY_COUNT_EN
  logic [15:0] count_q;

  // The counter steps on the same edge that raises out_nd. Flush does not
  // clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (out_nd_d) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign out_count = count_q;
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_sample_delay.sv
`default_nettype none
// ============================================================================
// Module   : tb_sample_delay
// Purpose  : Self-checking bench for sample_delay. It runs two instances
//            (DEPTH=4 and DEPTH=1) from shared inputs. A queue-based model
//            predicts the outputs: a sample leaves the queue when a new one
//            arrives and DEPTH samples are already held.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sample_delay;

  localparam int WDTH  = 16;
  localparam int MWDTH = 2;
  localparam int D0    = 4;
  localparam int D1    = 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WDTH-1:0]  in_data;
  logic             in_nd;
  logic [MWDTH-1:0] in_m;
  logic             flush;

  logic [WDTH-1:0]  od0, od1;
  logic [MWDTH-1:0] om0, om1;
  logic             ond0, ond1, pr0, pr1, er0, er1;
`ifdef SAMPLE_DELAY_COUNT_EN
  logic [15:0]      cnt0, cnt1;
`endif

  always #5 clk = ~clk;

  sample_delay #(.WDTH(WDTH), .MWDTH(MWDTH), .DEPTH(D0)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_nd(in_nd), .in_m(in_m),
    .flush(flush), .out_data(od0), .out_nd(ond0), .out_m(om0),
    .primed(pr0), .error(er0)
`ifdef SAMPLE_DELAY_COUNT_EN
    , .out_count(cnt0)
`endif
  );

  sample_delay #(.WDTH(WDTH), .MWDTH(MWDTH), .DEPTH(D1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_nd(in_nd), .in_m(in_m),
    .flush(flush), .out_data(od1), .out_nd(ond1), .out_m(om1),
    .primed(pr1), .error(er1)
`ifdef SAMPLE_DELAY_COUNT_EN
    , .out_count(cnt1)
`endif
  );

  // Reference model state
  logic [MWDTH+WDTH-1:0] q0[$], q1[$];
  logic [MWDTH+WDTH-1:0] pair;
  logic [WDTH-1:0]  e_d0, e_d1;
  logic [MWDTH-1:0] e_m0, e_m1;
  logic             e_nd0, e_nd1, e_err;
  int               e_cnt0, e_cnt1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q0.delete(); q1.delete();
    e_d0 = '0; e_d1 = '0; e_m0 = '0; e_m1 = '0;
    e_nd0 = 1'b0; e_nd1 = 1'b0; e_err = 1'b0;
    e_cnt0 = 0; e_cnt1 = 0;
  endtask

  // Model reaction to one clock edge with the given inputs.
  task automatic model_edge(input logic nd, input logic fl,
                            input logic [WDTH-1:0] d, input logic [MWDTH-1:0] m);
    e_nd0 = 1'b0;
    e_nd1 = 1'b0;
    if (fl) begin
      q0.delete(); q1.delete();
      if (nd) e_err = 1'b1;
    end else if (nd) begin
      if (q0.size() == D0) begin
        pair = q0.pop_front();
        {e_m0, e_d0} = pair;
        e_nd0 = 1'b1;
        e_cnt0++;
      end
      q0.push_back({m, d});
      if (q1.size() == D1) begin
        pair = q1.pop_front();
        {e_m1, e_d1} = pair;
        e_nd1 = 1'b1;
        e_cnt1++;
      end
      q1.push_back({m, d});
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".d4.nd"},     32'(ond0), 32'(e_nd0));
    chk({ph, ".d4.data"},   32'(od0),  32'(e_d0));
    chk({ph, ".d4.m"},      32'(om0),  32'(e_m0));
    chk({ph, ".d4.primed"}, 32'(pr0),  32'(q0.size() == D0));
    chk({ph, ".d4.error"},  32'(er0),  32'(e_err));
    chk({ph, ".d1.nd"},     32'(ond1), 32'(e_nd1));
    chk({ph, ".d1.data"},   32'(od1),  32'(e_d1));
    chk({ph, ".d1.m"},      32'(om1),  32'(e_m1));
    chk({ph, ".d1.primed"}, 32'(pr1),  32'(q1.size() == D1));
    chk({ph, ".d1.error"},  32'(er1),  32'(e_err));
`ifdef SAMPLE_DELAY_COUNT_EN
    chk({ph, ".d4.count"},  32'(cnt0), 32'(e_cnt0 % 65536));
    chk({ph, ".d1.count"},  32'(cnt1), 32'(e_cnt1 % 65536));
`endif
  endtask

  task automatic step(input string ph, input logic nd, input logic fl,
                      input logic [WDTH-1:0] d, input logic [MWDTH-1:0] m);
    @(negedge clk);
    in_nd   = nd;
    flush   = fl;
    in_data = d;
    in_m    = m;
    @(posedge clk);
    model_edge(nd, fl, d, m);
    #1;
    check_all(ph);
  endtask

  task automatic idle(input string ph, input int n);
    for (int i = 0; i < n; i++) step(ph, 1'b0, 1'b0, WDTH'($urandom), MWDTH'($urandom));
  endtask

  initial begin
    rst_n   = 1'b0;
    in_nd   = 1'b0;
    flush   = 1'b0;
    in_data = '0;
    in_m    = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // Back-to-back inputs 1..8, metadata cycling 0..3
    for (int i = 1; i <= 8; i++) step("b2b", 1'b1, 1'b0, WDTH'(i), MWDTH'(i));
    idle("b2b_tail", 2);

    // Idle gaps between inputs; outputs hold between pulses
    for (int i = 1; i <= 6; i++) begin
      step("gap", 1'b1, 1'b0, WDTH'(16'h100 + i), MWDTH'(i));
      idle("gap_idle", 3);
    end

    // Flush then refill: nothing comes out until DEPTH+1 new inputs
    step("flush", 1'b0, 1'b1, '0, '0);
    for (int i = 7; i <= 11; i++) step("refill", 1'b1, 1'b0, WDTH'(i), MWDTH'(i));
    idle("refill_tail", 2);

    // Flush with in_nd in the same cycle: sample dropped, sticky error
    for (int i = 0; i < 5; i++) step("pre_err", 1'b1, 1'b0, WDTH'($urandom), MWDTH'($urandom));
    step("err_inj", 1'b1, 1'b1, 16'h00AA, 2'd2);
    for (int i = 0; i < 6; i++) step("post_err", 1'b1, 1'b0, WDTH'($urandom), MWDTH'($urandom));

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 3),
           WDTH'($urandom), MWDTH'($urandom));
    end

    // Asynchronous reset while primed: outputs drop without a clock edge
    for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, 1'b0, WDTH'($urandom), MWDTH'($urandom));
    @(negedge clk);
    in_nd = 1'b0;
    flush = 1'b0;
    @(posedge clk);
    model_edge(1'b0, 1'b0, '0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step("post_rst", 1'b1, 1'b0, WDTH'($urandom), MWDTH'($urandom));

    // More random traffic without flush collisions
    for (int i = 0; i < 200; i++) begin
      step("rand2", ($urandom_range(0, 99) < 70), 1'b0, WDTH'($urandom), MWDTH'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
